// File: rtl/mem_pkg.sv
// Shared types for the store write buffer.
// Holds default widths, the buffer entry layout and a word-address helper.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      valid;
    logic [MEM_ADDR_WIDTH-3:0] word_addr;
    logic [MEM_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic [MEM_ADDR_WIDTH-3:0] word_addr(
    input logic [MEM_ADDR_WIDTH-1:0] a
  );
    return a[MEM_ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Memory drain port of the store write buffer (valid/ready style).
// master: buffer side (we/addr/wdata out, ready in); slave: memory side.
interface store_write_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/store_write_buffer_match.sv
// DEPTH-way word-address comparator over the buffer entries.
// Ports: valid_i/waddr_i (entries), key_i (lookup), match_o (one-hot), hit_o.
module store_write_buffer_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [AW-1:0]    waddr_i [DEPTH],
  input  logic [AW-1:0]    key_i,
  output logic [DEPTH-1:0] match_o,
  output logic             hit_o
);

  // One-hot because the buffer never holds two valid entries per word.
  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_i[i] && (waddr_i[i] == key_i);
    end
  end

  assign hit_o = |match_o;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between write-through cache and memory: merges
// repeat word stores, forwards buffered data to loads, drains in order.
// Ports: clk_i/rst_i, store (wr_*, stall_o), load forward (rd_addr_i,
// fwd_*), memory drain interface mem (master), empty_o, count_o.
module store_write_buffer
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_WIDTH-1:0]    wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  output logic                     stall_o,
  input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
  output logic                     fwd_hit_o,
  output logic [DATA_WIDTH-1:0]    fwd_data_o,
  store_write_buffer_if.master     mem,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = ADDR_WIDTH - 2;

  wb_entry_t         entries_q [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;

  logic [DEPTH-1:0]  ent_valid;
  logic [AW-1:0]     ent_waddr [DEPTH];
  logic [DEPTH-1:0]  st_match;
  logic              st_hit;
  logic [DEPTH-1:0]  ld_match;
  logic              ld_hit;

  logic              empty;
  logic              full;
  logic              pop;
  logic              merge;
  logic              alloc;

  logic              unused_lsb;
  assign unused_lsb = ^{wr_addr_i[1:0], rd_addr_i[1:0]};

  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries_q[i].valid;
      ent_waddr[i] = entries_q[i].word_addr;
    end
  end

  store_write_buffer_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_st_match (
    .valid_i (ent_valid),
    .waddr_i (ent_waddr),
    .key_i   (word_addr(wr_addr_i)),
    .match_o (st_match),
    .hit_o   (st_hit)
  );

  store_write_buffer_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ld_match (
    .valid_i (ent_valid),
    .waddr_i (ent_waddr),
    .key_i   (word_addr(rd_addr_i)),
    .match_o (ld_match),
    .hit_o   (ld_hit)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = !empty && mem.mem_ready;

  // A store hitting the head as it leaves becomes a fresh tail entry so
  // memory sees the old value first, then the new one.
  assign merge = wr_en_i && st_hit && !(st_match[head_q] && pop);
  assign alloc = wr_en_i && !merge && !full;
  assign stall_o = wr_en_i && !merge && full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        entries_q[head_q].valid <= 1'b0;
        head_q <= head_q + PW'(1);
      end
      if (merge) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (st_match[i]) begin
            entries_q[i].data <= wr_data_i;
          end
        end
      end
      if (alloc) begin
        entries_q[tail_q].valid     <= 1'b1;
        entries_q[tail_q].word_addr <= word_addr(wr_addr_i);
        entries_q[tail_q].data      <= wr_data_i;
        tail_q <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
    end
  end

  always_comb begin
    fwd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_match[i]) begin
        fwd_data_o = fwd_data_o | entries_q[i].data;
      end
    end
  end

  assign fwd_hit_o     = ld_hit;
  assign mem.mem_we    = !empty;
  assign mem.mem_addr  = {entries_q[head_q].word_addr, 2'b00};
  assign mem.mem_wdata = entries_q[head_q].data;
  assign empty_o       = empty;
  assign count_o       = count_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer.
// Memory writes are checked by a scoreboard monitor; status by direct checks.
module tb_store_write_buffer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        stall;
  logic [31:0] rd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        empty;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];

  store_write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  store_write_buffer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .stall_o    (stall),
    .rd_addr_i  (rd_addr),
    .fwd_hit_o  (fwd_hit),
    .fwd_data_o (fwd_data),
    .mem        (bus.master),
    .empty_o    (empty),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    #1;
    chk("store_stall", {31'b0, stall}, 32'd0);
    step();
    wr_en = 1'b0;
  endtask

  // Memory-side monitor: every accepted write must match the next expected.
  always @(negedge clk) begin
    if (!rst && bus.mem_we && bus.mem_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL mem_unexpected: got %h=%h expected none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d) begin
          miscompares++;
          $display("FAIL mem_write: got %h=%h expected %h=%h",
                   bus.mem_addr, bus.mem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic drain_all(input string name);
    int n;
    n = 0;
    bus.mem_ready = 1'b1;
    while (!empty && n < 12) begin
      step();
      n++;
    end
    bus.mem_ready = 1'b0;
    #1;
    chk(name, {31'b0, empty}, 32'd1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = 32'h104;
    bus.mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_fwd_hit", {31'b0, fwd_hit}, 32'd0);

    // Three stores held back by memory.
    store(32'h100, 32'hA0A0_0001);
    store(32'h104, 32'hB0B0_0002);
    store(32'h108, 32'hC0C0_0003);
    expect_wr(32'h100, 32'hA0A0_0001);
    expect_wr(32'h104, 32'hB0B0_0002);
    expect_wr(32'h108, 32'hC0C0_0003);
    #1;
    chk("fill_count", {29'b0, count}, 32'd3);
    chk("fill_we", {31'b0, bus.mem_we}, 32'd1);
    chk("fill_addr", bus.mem_addr, 32'h100);
    chk("fill_wdata", bus.mem_wdata, 32'hA0A0_0001);
    step();
    chk("hold_addr", bus.mem_addr, 32'h100);
    chk("hold_wdata", bus.mem_wdata, 32'hA0A0_0001);
    chk("fwd_hit_b", {31'b0, fwd_hit}, 32'd1);
    chk("fwd_data_b", fwd_data, 32'hB0B0_0002);
    rd_addr = 32'h10C;
    #1;
    chk("fwd_miss", {31'b0, fwd_hit}, 32'd0);
    rd_addr = 32'h106;

    // Drain A, B, C.
    bus.mem_ready = 1'b1;
    step();
    step();
    chk("fwd_gone_hit", {31'b0, fwd_hit}, 32'd0);
    chk("fwd_gone_data", fwd_data, 32'd0);
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("drain_empty", {31'b0, empty}, 32'd1);
    chk("drain_count", {29'b0, count}, 32'd0);

    // Merge into the same word.
    store(32'h200, 32'd1);
    store(32'h203, 32'd2);
    expect_wr(32'h200, 32'd2);
    #1;
    chk("merge_count", {29'b0, count}, 32'd1);
    chk("merge_wdata", bus.mem_wdata, 32'd2);
    drain_all("merge_empty");

    // Full buffer.
    store(32'h400, 32'h10);
    store(32'h404, 32'h11);
    store(32'h408, 32'h12);
    store(32'h40C, 32'h13);
    #1;
    chk("full_count", {29'b0, count}, 32'd4);
    wr_en = 1'b1;
    wr_addr = 32'h410;
    wr_data = 32'h14;
    #1;
    chk("full_stall", {31'b0, stall}, 32'd1);
    step();
    chk("full_hold_count", {29'b0, count}, 32'd4);
    rd_addr = 32'h410;
    #1;
    chk("full_no_fwd", {31'b0, fwd_hit}, 32'd0);
    wr_addr = 32'h408;
    wr_data = 32'h99;
    #1;
    chk("full_merge_stall", {31'b0, stall}, 32'd0);
    step();
    wr_en = 1'b0;
    rd_addr = 32'h408;
    #1;
    chk("full_merge_count", {29'b0, count}, 32'd4);
    chk("full_merge_fwd", fwd_data, 32'h99);
    expect_wr(32'h400, 32'h10);
    expect_wr(32'h404, 32'h11);
    expect_wr(32'h408, 32'h99);
    expect_wr(32'h40C, 32'h13);
    expect_wr(32'h410, 32'h14);
    wr_en = 1'b1;
    wr_addr = 32'h410;
    wr_data = 32'h14;
    bus.mem_ready = 1'b1;
    #1;
    chk("full_pop_stall", {31'b0, stall}, 32'd1);
    step();
    chk("after_pop_count", {29'b0, count}, 32'd3);
    chk("after_pop_stall", {31'b0, stall}, 32'd0);
    step();
    wr_en = 1'b0;
    chk("push_pop_count", {29'b0, count}, 32'd3);
    drain_all("full_drain_empty");

    // Head race: store to the draining head word.
    store(32'h300, 32'hDEAD_0001);
    expect_wr(32'h300, 32'hDEAD_0001);
    expect_wr(32'h300, 32'hDEAD_0002);
    bus.mem_ready = 1'b1;
    wr_en = 1'b1;
    wr_addr = 32'h300;
    wr_data = 32'hDEAD_0002;
    #1;
    chk("race_stall", {31'b0, stall}, 32'd0);
    step();
    wr_en = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("race_count", {29'b0, count}, 32'd1);
    chk("race_wdata", bus.mem_wdata, 32'hDEAD_0002);
    drain_all("race_empty");

    // Reset with pending entries discards them.
    store(32'h500, 32'h5);
    store(32'h504, 32'h6);
    store(32'h508, 32'h7);
    #1;
    chk("pre_rst_count", {29'b0, count}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, bus.mem_we}, 32'd0);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_count", {29'b0, count}, 32'd0);
    step();
    step();

    chk("sb_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
